fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 bubble driven whenever the output buffer is empty
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, 1-entry output buffer.
// Optional misaligned-redirect fault via `FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ready_in,
  input  logic                      redirect_valid,
  input  logic [fetch_pkg::XLEN-1:0] redirect_pc,
  output logic                      imem_req,
  output logic [fetch_pkg::XLEN-1:0] imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [fetch_pkg::XLEN-1:0] imem_rdata,
  output logic                      valid_out,
  output logic [fetch_pkg::XLEN-1:0] instr_out,
  output logic [fetch_pkg::XLEN-1:0] pc_out,
  output logic [fetch_pkg::XLEN-1:0] pc4_out,
  output logic                      fetch_fault_out
);
  import fetch_pkg::XLEN;
  import fetch_pkg::fetch_state_t;
  import fetch_pkg::IDLE;
  import fetch_pkg::REQ;
  import fetch_pkg::WAIT;
  import fetch_pkg::pc_inc;

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_drop, w_drop_nxt;
  logic            r_req, w_req_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_valid, w_valid_nxt;
  logic [XLEN-1:0] r_instr, w_instr_nxt;
  logic [XLEN-1:0] r_pc_out, w_pc_out_nxt;
  logic [XLEN-1:0] r_pc4, w_pc4_nxt;

  logic            w_halt;
  logic            w_issue;
  logic            w_consume;
  logic [XLEN-1:0] w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault, w_fault_nxt;

  assign w_halt          = r_fault;
  assign w_redir_pc      = redirect_pc;
  assign fetch_fault_out = r_fault;

  always_ff @(posedge clk) begin
    if (reset) r_fault <= 1'b0;
    else       r_fault <= w_fault_nxt;
  end
`else
  assign w_halt          = 1'b0;
  assign w_redir_pc      = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault_out = 1'b0;
`endif

  // Start a fetch only when the buffer is empty or draining this cycle.
  assign w_issue   = (r_state == IDLE) & (~r_valid | ready_in) & ~redirect_valid & ~w_halt;
  assign w_consume = r_valid & ready_in & ~w_halt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue)     w_state_nxt = REQ;
      REQ:     if (imem_gnt)    w_state_nxt = WAIT;
      WAIT:    if (imem_rvalid) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; redirect is applied last so it wins.
  always_comb begin
    w_pc_nxt     = r_pc;
    w_drop_nxt   = r_drop;
    w_addr_nxt   = r_addr;
    w_valid_nxt  = r_valid;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_pc4_nxt    = r_pc4;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_fault_nxt  = r_fault;
`endif
    w_req_nxt    = w_issue | ((r_state == REQ) & ~imem_gnt);

    if (w_issue) w_addr_nxt = r_pc;

    if (w_consume) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
    end

    if ((r_state == WAIT) && imem_rvalid) begin
      w_drop_nxt = 1'b0;
      if (!r_drop && !redirect_valid) begin
        w_instr_nxt  = imem_rdata;
        w_pc_out_nxt = r_addr;
        w_pc4_nxt    = pc_inc(r_addr);
        w_valid_nxt  = 1'b1;
        w_pc_nxt     = pc_inc(r_pc);
      end
    end

    if (redirect_valid) begin
      w_pc_nxt    = w_redir_pc;
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
      // The in-flight request still completes; its response must be thrown away.
      if ((r_state == REQ) || ((r_state == WAIT) && !imem_rvalid)) w_drop_nxt = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      w_fault_nxt = |redirect_pc[1:0];
      if (|redirect_pc[1:0]) begin
        w_valid_nxt  = 1'b1;
        w_pc_out_nxt = redirect_pc;
        w_pc4_nxt    = pc_inc(redirect_pc);
      end
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_drop   <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_pc_out <= '0;
      r_pc4    <= '0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_valid  <= w_valid_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_pc4    <= w_pc4_nxt;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign valid_out = r_valid;
  assign instr_out = r_instr;
  assign pc_out    = r_pc_out;
  assign pc4_out   = r_pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level fetch model and a
// randomly-delayed instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned N_CYC = 3000;

  logic        clk;
  logic        reset;
  logic        ready_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        fetch_fault_out;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .ready_in        (ready_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .valid_out       (valid_out),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .pc4_out         (pc4_out),
    .fetch_fault_out (fetch_fault_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec;
  int unsigned n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents; address 0 holds addi x1,x0,5.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
  endfunction

  // Reference model: next fetch PC, buffer contents, outstanding-request bookkeeping.
  logic [31:0] m_pc, m_ra, m_bpc, m_binstr;
  bit          m_valid, m_out, m_inreq, m_stale, m_fault;
  // Memory model
  bit          mp;
  int          md;
  logic [31:0] ma;

  bit          e_reset, rst_now, quiet, rdy, redir, gnt, rv, fill, issue;
  logic [31:0] rpc, rdat;

  task automatic model_reset();
    m_pc = 32'h0; m_ra = 32'h0; m_bpc = 32'h0; m_binstr = NOP;
    m_valid = 0; m_out = 0; m_inreq = 0; m_stale = 0; m_fault = 0;
    mp = 0; md = 0; ma = 32'h0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; ready_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    e_reset = 1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;
      if (e_reset) begin
        chk("rst_req",   32'(imem_req),        32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", 32'(valid_out),       32'h0);
        chk("rst_instr", instr_out,            NOP);
        chk("rst_pc",    pc_out,               32'h0);
        chk("rst_pc4",   pc4_out,              32'h0);
        chk("rst_fault", 32'(fetch_fault_out), 32'h0);
      end else begin
        chk("req", 32'(imem_req), 32'(m_inreq));
        if (m_inreq) chk("addr", imem_addr, m_ra);
        chk("valid", 32'(valid_out), 32'(m_valid));
        chk("fault", 32'(fetch_fault_out), 32'(m_fault));
        if (m_valid) begin
          chk("pc", pc_out, m_bpc);
          chk("instr", instr_out, m_binstr);
          if (!m_fault) chk("pc4", pc4_out, m_bpc + 32'd4);
        end else begin
          chk("nop", instr_out, NOP);
        end
      end

      rst_now = (cyc < 3) || (cyc >= 1500 && cyc < 1502);
      if (rst_now) begin
        reset = 1'b1; ready_in = 1'b0; redirect_valid = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        model_reset();
        e_reset = 1;
      end else begin
        e_reset = 0;
        quiet = (cyc >= 300 && cyc < 360) || (cyc >= 2600 && cyc < 2660);
        rdy   = ((cyc % 200) < 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
        redir = ($urandom_range(0, 15) == 0);
        rpc   = 32'($urandom_range(0, 4095));
        if (quiet) begin redir = 0; rdy = 1; end
        if (cyc == 300)  begin redir = 1; rpc = 32'hFFFF_FFF4; end
        if (cyc == 2600) begin redir = 1; rpc = 32'h0000_0102; end
        if (cyc == 2620) begin redir = 1; rpc = 32'h0000_0200; end

        rv = 0;
        rdat = 32'($urandom);
        if (mp) begin
          if (md == 0) begin rv = 1; mp = 0; rdat = memf(ma); end
          else md--;
        end
        gnt = imem_req && ($urandom_range(0, 2) != 0);
        if (gnt) begin mp = 1; ma = imem_addr; md = $urandom_range(0, 3); end

        reset = 1'b0;
        ready_in = rdy; redirect_valid = redir; redirect_pc = rpc;
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdat;

        fill  = m_out && rv && !m_stale && !redir;
        issue = !m_out && (!m_valid || rdy) && !redir && !m_fault;
        if (m_inreq && gnt) m_inreq = 0;
        if (m_out && redir) m_stale = 1;
        if (m_out && rv) m_out = 0;
        if (fill) begin
          m_valid = 1; m_bpc = m_ra; m_binstr = memf(m_ra); m_pc = m_pc + 32'd4;
        end else if (redir) begin
          m_valid = 0; m_fault = 0; m_pc = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (rpc[1:0] != 2'b00) begin
            m_fault = 1; m_valid = 1; m_bpc = rpc; m_binstr = NOP;
          end
`endif
        end else if (m_valid && rdy && !m_fault) begin
          m_valid = 0;
        end
        if (issue) begin m_out = 1; m_inreq = 1; m_stale = 0; m_ra = m_pc; end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
